// File: rtl/reg_16_ctrl_pkg.sv
// reg_16_ctrl_pkg: shared definitions for the 16-bit register-bank sequencer.
//   - default bank geometry (NWORDS_DEF, AW_DEF, DW_DEF)
//   - FSM state encoding (VREAD/VCHK exist only when WRITE_VERIFY_EN is defined)
//   - onehot_dec(): word address to one-hot select mask with range check
package reg_16_ctrl_pkg;

  localparam int NWORDS_DEF = 4;
  localparam int AW_DEF     = 2;
  localparam int DW_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_DONE   = 3'd3
`ifdef WRITE_VERIFY_EN
    ,
    ST_VREAD  = 3'd4,
    ST_VCHK   = 3'd5
`endif
  } state_t;

  // Returns a one-hot mask for addr, or all-zero when addr is outside the bank.
  // Supports banks of up to 32 words.
  function automatic logic [31:0] onehot_dec(input logic [31:0] addr, input int nwords);
    logic [31:0] mask;
    mask = 32'd0;
    if (addr < 32'(nwords)) begin
      mask = 32'd1 << addr;
    end else begin
      mask = 32'd0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/reg_16_ctrl_if.sv
// reg_16_ctrl_if: requester handshake plus register-bank control lines.
//   Requester side : REQ, WE, ADDR, DIN -> ACK, ERR, DOUT, BUSY
//   Bank side      : CS, R, W, D -> bank, RD_DATA <- bank
// Modports: slave (the sequencer), master (requester/bank environment).
interface reg_16_ctrl_if
  import reg_16_ctrl_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF
);

  logic              REQ;
  logic              WE;
  logic [AW-1:0]     ADDR;
  logic [DW-1:0]     DIN;
  logic              ACK;
  logic              ERR;
  logic [DW-1:0]     DOUT;
  logic              BUSY;
  logic [NWORDS-1:0] CS;
  logic              R;
  logic              W;
  logic [DW-1:0]     D;
  logic [DW-1:0]     RD_DATA;

  modport slave (
    input  REQ, WE, ADDR, DIN, RD_DATA,
    output ACK, ERR, DOUT, BUSY, CS, R, W, D
  );

  modport master (
    output REQ, WE, ADDR, DIN, RD_DATA,
    input  ACK, ERR, DOUT, BUSY, CS, R, W, D
  );

endinterface

// File: rtl/reg_16_ctrl_dec.sv
// reg_16_ctrl_dec: word address to one-hot chip select.
//   addr  : word address
//   cs    : one-hot select, all-zero when addr >= NWORDS
//   valid : 1 when addr addresses an existing word
module reg_16_ctrl_dec
  import reg_16_ctrl_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic [AW-1:0]     addr,
  output logic [NWORDS-1:0] cs,
  output logic              valid
);

  logic [31:0] addr_ext_s;
  logic [31:0] mask_s;

  // Decode via the shared helper; an empty mask means out of range.
  always_comb begin
    addr_ext_s = 32'(addr);
    mask_s     = onehot_dec(addr_ext_s, NWORDS);
    cs         = mask_s[NWORDS-1:0];
    valid      = (mask_s != 32'd0);
  end

endmodule

// File: rtl/reg_16_ctrl.sv
// reg_16_ctrl: single-word read/write sequencer for a bank of 16-bit registers.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : reg_16_ctrl_if.slave (REQ/WE/ADDR/DIN in, ACK/ERR/DOUT/BUSY out,
//              CS/R/W/D to the bank, RD_DATA from the bank)
// Sequence: IDLE -> SETUP -> STROBE -> DONE (ACK three cycles after REQ is taken).
// Optional macro WRITE_VERIFY_EN: writes insert VREAD/VCHK to read the word back
// and flag a mismatch on ERR (write latency five cycles).
// All outputs are registered from the next state, so they change on the same
// edge as the state and clear asynchronously with RST.
module reg_16_ctrl
  import reg_16_ctrl_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF
) (
  input logic          CLK,
  input logic          RST,
  reg_16_ctrl_if.slave bus
);

  state_t            state_r;
  state_t            state_s;

  logic              we_r;
  logic              valid_r;
  logic [AW-1:0]     addr_r;
  logic [DW-1:0]     din_r;

  logic [AW-1:0]     addr_sel_s;
  logic [NWORDS-1:0] cs_dec_s;
  logic              valid_dec_s;

  logic [NWORDS-1:0] cs_s;
  logic              r_s;
  logic              w_s;
  logic              ack_s;
  logic              err_s;
  logic              busy_s;
  logic [DW-1:0]     d_s;

  logic [NWORDS-1:0] cs_r;
  logic              r_r;
  logic              w_r;
  logic              ack_r;
  logic              err_r;
  logic              busy_r;
  logic [DW-1:0]     d_r;
  logic [DW-1:0]     dout_r;

`ifdef WRITE_VERIFY_EN
  logic [DW-1:0]     vdata_r;
`endif

  // In IDLE decode the live request address so CS is ready for the SETUP edge;
  // afterwards decode the latched address.
  always_comb begin
    if (state_r == ST_IDLE) begin
      addr_sel_s = bus.ADDR;
    end else begin
      addr_sel_s = addr_r;
    end
  end

  reg_16_ctrl_dec #(
    .NWORDS (NWORDS),
    .AW     (AW)
  ) u_dec (
    .addr  (addr_sel_s),
    .cs    (cs_dec_s),
    .valid (valid_dec_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    cs_s    = {NWORDS{1'b0}};
    r_s     = 1'b0;
    w_s     = 1'b0;
    ack_s   = 1'b0;
    err_s   = 1'b0;
    d_s     = d_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.REQ) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_s = ST_STROBE;
`ifdef WRITE_VERIFY_EN
      ST_STROBE: begin
        if (we_r) begin
          state_s = ST_VREAD;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_VREAD:  state_s = ST_VCHK;
      ST_VCHK:   state_s = ST_DONE;
`else
      ST_STROBE: state_s = ST_DONE;
`endif
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase

    // Outputs for the state being entered; cs_dec_s is zero for a bad address,
    // which also keeps CS idle on invalid transactions.
    case (state_s)
      ST_SETUP: begin
        cs_s = cs_dec_s;
        d_s  = bus.DIN;
      end
      ST_STROBE: begin
        cs_s = cs_dec_s;
        d_s  = din_r;
        w_s  = we_r & valid_r;
        r_s  = ~we_r & valid_r;
      end
`ifdef WRITE_VERIFY_EN
      ST_VREAD: begin
        cs_s = cs_dec_s;
        r_s  = valid_r;
      end
      ST_VCHK: begin
        cs_s = {NWORDS{1'b0}};
      end
`endif
      ST_DONE: begin
        ack_s = 1'b1;
`ifdef WRITE_VERIFY_EN
        err_s = ~valid_r | ((state_r == ST_VCHK) && (vdata_r != din_r));
`else
        err_s = ~valid_r;
`endif
      end
      default: begin
        cs_s = {NWORDS{1'b0}};
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture: only an IDLE-cycle REQ is taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_r    <= 1'b0;
      valid_r <= 1'b0;
      addr_r  <= {AW{1'b0}};
      din_r   <= {DW{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.REQ) begin
      we_r    <= bus.WE;
      valid_r <= valid_dec_s;
      addr_r  <= bus.ADDR;
      din_r   <= bus.DIN;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cs_r   <= {NWORDS{1'b0}};
      r_r    <= 1'b0;
      w_r    <= 1'b0;
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
      d_r    <= {DW{1'b0}};
    end else begin
      cs_r   <= cs_s;
      r_r    <= r_s;
      w_r    <= w_s;
      ack_r  <= ack_s;
      err_r  <= err_s;
      busy_r <= busy_s;
      d_r    <= d_s;
    end
  end

  // Read data is captured at the end of a valid read strobe only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_r <= {DW{1'b0}};
    end else if ((state_r == ST_STROBE) && !we_r && valid_r) begin
      dout_r <= bus.RD_DATA;
    end
  end

`ifdef WRITE_VERIFY_EN
  // Verify read-back, kept separate so DOUT is untouched by verify reads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vdata_r <= {DW{1'b0}};
    end else if (state_r == ST_VREAD) begin
      vdata_r <= bus.RD_DATA;
    end
  end
`endif

  assign bus.CS   = cs_r;
  assign bus.R    = r_r;
  assign bus.W    = w_r;
  assign bus.ACK  = ack_r;
  assign bus.ERR  = err_r;
  assign bus.BUSY = busy_r;
  assign bus.D    = d_r;
  assign bus.DOUT = dout_r;

endmodule

// File: tb/tb_reg_16_ctrl.sv
// tb_reg_16_ctrl: scoreboard bench for reg_16_ctrl (4-word bank, 3-bit address
// so out-of-range addresses can be exercised). A bank model answers RD_DATA and
// absorbs writes; a word-level reference model predicts ACK timing, ERR and DOUT.
module tb_reg_16_ctrl;

  localparam int NW = 4;
  localparam int AW = 3;
  localparam int DW = 16;
`ifdef WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  reg_16_ctrl_if #(.NWORDS(NW), .AW(AW), .DW(DW)) bus ();

  reg_16_ctrl #(.NWORDS(NW), .AW(AW), .DW(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bank model ----------------
  logic [DW-1:0] bank [NW] = '{default: 16'h0000};
  logic          corrupt = 1'b0;

  always @(posedge CLK) begin
    for (int i = 0; i < NW; i++) begin
      if (bus.W && bus.CS[i]) bank[i] <= bus.D;
    end
  end

  always_comb begin : bank_rd
    logic [DW-1:0] v;
    v = 16'hDEAD;
    for (int i = 0; i < NW; i++) begin
      if (bus.CS[i]) v = bank[i];
    end
    if (corrupt) v = v ^ 16'h0001;
    bus.RD_DATA = v;
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int            ack_cyc;
    logic          err;
    logic [DW-1:0] dout;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [NW] = '{default: 16'h0000};
  logic [DW-1:0] ref_dout = 16'h0000;

  // Current transaction, used by the monitor for strobe/select timing.
  int            cur_e     = -100;
  logic          cur_we    = 1'b0;
  logic          cur_valid = 1'b0;
  logic [NW-1:0] cur_cs    = '0;
  logic [DW-1:0] cur_din   = '0;

  task automatic set_cur(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    cur_e     = cyc + 1;
    cur_we    = we;
    cur_valid = (int'(addr) < NW);
    cur_din   = din;
    for (int i = 0; i < NW; i++) cur_cs[i] = cur_valid && (int'(addr) == i);
  endtask

  task automatic push_exp(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din, input logic corr);
    exp_t e;
    int   lat;
    set_cur(we, addr, din);
    lat = (we && VERIFY) ? 5 : 3;
    if (cur_valid && we)  ref_mem[int'(addr)] = din;
    if (cur_valid && !we) ref_dout = ref_mem[int'(addr)];
    e.ack_cyc = cur_e + lat - 1;
    e.err     = !cur_valid || (we && VERIFY && corr);
    e.dout    = ref_dout;
    sbq.push_back(e);
  endtask

  // Monitor: strobe/select shape every cycle, completions against the queue.
  always @(negedge CLK) begin : mon
    int            rel;
    logic [1:0]    exp_wr;
    logic [NW-1:0] exp_cs;
    exp_t          e;
    if (!RST) begin
      rel    = cyc - cur_e + 1;
      exp_wr = 2'b00;
      exp_cs = '0;
      if (cur_valid && (rel == 1 || rel == 2 || (rel == 3 && cur_we && VERIFY))) exp_cs = cur_cs;
      if (cur_valid && rel == 2) exp_wr = cur_we ? 2'b10 : 2'b01;
      if (cur_valid && rel == 3 && cur_we && VERIFY) exp_wr = 2'b01;
      if ({bus.W, bus.R} != 2'b00 || exp_wr != 2'b00) check("strobe_WR", {bus.W, bus.R}, exp_wr);
      if (bus.CS != '0 || exp_cs != '0) check("cs", bus.CS, exp_cs);
      if (bus.W) check("d_at_write", bus.D, cur_din);
      if (bus.ACK) begin
        check("ack_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("ack_cycle", cyc, e.ack_cyc);
          check("err", bus.ERR, e.err);
          check("dout", bus.DOUT, e.dout);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) return;
    end
    check("idle_timeout", bus.BUSY, 0);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] din, input logic corr);
    wait_idle();
    bus.REQ  = 1'b1;
    bus.WE   = we;
    bus.ADDR = addr;
    bus.DIN  = din;
    corrupt  = corr;
    push_exp(we, addr, din, corr);
    @(negedge CLK);
    bus.REQ  = 1'b0;
    bus.WE   = 1'($urandom);
    bus.ADDR = AW'($urandom);
    bus.DIN  = DW'($urandom);
  endtask

  initial begin
    bus.REQ  = 1'b0;
    bus.WE   = 1'b0;
    bus.ADDR = '0;
    bus.DIN  = '0;
    RST      = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ack", bus.ACK, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_r", bus.R, 0);
    check("rst_w", bus.W, 0);
    check("rst_cs", bus.CS, 0);
    check("rst_d", bus.D, 0);
    check("rst_dout", bus.DOUT, 0);
    RST = 1'b0;

    // Directed write, read-back, out-of-range read and write.
    issue(1'b1, 3'd2, 16'hA5A5, 1'b0);
    issue(1'b0, 3'd2, 16'h0000, 1'b0);
    issue(1'b0, 3'd5, 16'h0000, 1'b0);
    issue(1'b1, 3'd7, 16'h1111, 1'b0);

    // REQ re-pulsed while busy must be ignored.
    issue(1'b1, 3'd1, 16'h5A5A, 1'b0);
    bus.REQ  = 1'b1;
    bus.WE   = 1'b1;
    bus.ADDR = 3'd3;
    bus.DIN  = 16'hFFFF;
    @(negedge CLK);
    bus.REQ  = 1'b0;
    issue(1'b0, 3'd3, 16'h0000, 1'b0);

    // REQ held high: back-to-back reads every four cycles.
    wait_idle();
    bus.REQ  = 1'b1;
    bus.WE   = 1'b0;
    bus.ADDR = 3'd1;
    corrupt  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, 3'd1, bus.DIN, 1'b0);
      if (k < 2) repeat (4) @(negedge CLK);
      else @(negedge CLK);
    end
    bus.REQ = 1'b0;

    // Read-back mismatch, then clean write (ERR only with verify enabled).
    issue(1'b1, 3'd0, 16'h1234, 1'b1);
    issue(1'b1, 3'd0, 16'h1234, 1'b0);
    issue(1'b0, 3'd0, 16'h0000, 1'b0);

    // Reset during the write strobe: lines drop at once, no ACK.
    wait_idle();
    bus.REQ  = 1'b1;
    bus.WE   = 1'b1;
    bus.ADDR = 3'd3;
    bus.DIN  = 16'hBEEF;
    corrupt  = 1'b0;
    set_cur(1'b1, 3'd3, 16'hBEEF);
    @(negedge CLK);
    bus.REQ = 1'b0;
    @(negedge CLK);
    check("w_before_rst", bus.W, 1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_w", bus.W, 0);
    check("rst_mid_cs", bus.CS, 0);
    check("rst_mid_busy", bus.BUSY, 0);
    check("rst_mid_ack", bus.ACK, 0);
    cur_valid = 1'b0;
    ref_dout  = 16'h0000;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    issue(1'b0, 3'd3, 16'h0000, 1'b0);
    issue(1'b1, 3'd3, 16'h0F0F, 1'b0);
    issue(1'b0, 3'd3, 16'h0000, 1'b0);

    // Randomized traffic, including out-of-range addresses.
    repeat (40) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), 1'b0);
    end

    wait_idle();
    repeat (3) @(negedge CLK);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_16_ctrl.md
# reg_16_ctrl

Transaction sequencer that sits directly upstream of a bank of 16-bit register cells. It accepts single-word read/write requests on a simple REQ/ACK handshake, decodes the address to a one-hot chip select, and drives the D/R/W/CS strobes with setup time. It then captures read data from the selected word and returns it with ACK. It is the only master of the bank's control lines.

## Interface
- NWORDS, 4: number of 16-bit register words in the bank
- AW, 2: address width; addresses >= NWORDS are invalid
- DW, 16: data width
- CLK  input  1  single clock; all state changes on rising edge
- RST  input  1  asynchronous, active-high reset
- REQ  input  1  request; sampled only in IDLE
- WE  input  1  1 = write, 0 = read; sampled with REQ
- ADDR  input  AW  word address; sampled with REQ
- DIN  input  DW  write data; sampled with REQ
- ACK  output  1  one-cycle completion pulse
- ERR  output  1  valid with ACK; 1 = invalid address (or verify mismatch)
- DOUT  output  DW  read data; valid with ACK on reads; held until next read completes
- BUSY  output  1  high in every state except IDLE
- CS  output  NWORDS  one-hot word select to bank
- R  output  1  read strobe to bank
- W  output  1  write strobe to bank
- D  output  DW  data to bank
- RD_DATA  input  DW  read data from the selected word

Clock is CLK. Reset RST is asynchronous and active-high.

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE (plus VREAD, VCHK with macro).
- IDLE: REQ=1 → latch WE/ADDR/DIN into internal registers, go SETUP. REQ=0 → stay.
- SETUP: drive D=latched DIN, CS=onehot(ADDR), R=W=0. Always → STROBE.
- STROBE: hold CS/D; assert W (write) or R (read) for exactly this cycle. Read: RD_DATA registered into DOUT on exit edge. → DONE (or VREAD, see Configuration).
- DONE: ACK=1 for one cycle, CS/R/W=0. ERR per rules below. → IDLE.
- Invalid address (ADDR >= NWORDS): sequence still runs; CS stays all-zero, R/W suppressed, DOUT unchanged, ERR=1 with ACK.
- REQ while BUSY: ignored, no queueing; requester must hold or re-issue after ACK.
- REQ held high through ACK: new transaction starts in the IDLE cycle after DONE (back-to-back period 4 cycles).
- R and W never high together. CS is never multi-hot.

## Timing
- Reset values: state IDLE; ACK, ERR, BUSY, R, W = 0; CS = 0; D = 0; DOUT = 0.
- REQ sampled at edge 0 → SETUP cycle 1, strobe cycle 2, ACK high cycle 3. Fixed 3-cycle latency, macro off.
- D/CS stable one full cycle before and during strobe.
- RST asserted mid-transaction: CS/R/W/ACK drop immediately (asynchronous). The transaction is lost with no ACK. Resume in IDLE on first edge after release.

## Configuration
- WRITE_VERIFY_EN defined: writes go STROBE → VREAD (R=1, same CS) → VCHK (compare RD_DATA, registered at VREAD exit, to latched DIN) → DONE. ERR=1 on mismatch. Write latency becomes 5 cycles. Reads are unchanged at 3. DOUT is not updated by verify reads.
- Undefined: no VREAD/VCHK states or compare logic. ERR reflects invalid address only.

## Structure
- Shared package: state encoding typedef, default NWORDS/AW/DW constants, one-hot decode function.
- One sub-module is natural: reg_16_ctrl_dec, the ADDR→one-hot CS decoder with range check. Everything else is in one FSM module.

## Test plan
- Write 0xA5A5 to ADDR 2 → CS=0100 cycles 1–2, W=1 cycle 2 only, ACK cycle 3, ERR=0.
- Read ADDR 2 with RD_DATA=0xA5A5 → R=1 cycle 2, DOUT=0xA5A5 and ACK cycle 3.
- ADDR=5 with NWORDS=4 → CS=0 throughout, no R/W, ACK+ERR cycle 3, DOUT unchanged.
- REQ pulsed again during SETUP/STROBE → ignored, exactly one ACK. REQ held high → ACKs every 4 cycles.
- RST asserted during STROBE → W/CS low immediately, no ACK, BUSY=0. Next REQ completes normally.
- WRITE_VERIFY_EN: write 0x1234 with RD_DATA forced 0x1235 in VREAD → ACK cycle 5, ERR=1. Forced 0x1234 → ERR=0.
